// File: rtl/sdf_delay_line.sv
// Run-time-length complex-sample delay line for SDF FFT feedback paths.
// Storage is a DEPTH-stage shift register; the output tap selects stage[len_eff-1].
module sdf_delay_line #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [LW-1:0]    len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_r,
  output logic [WIDTH-1:0] out_i,
  output logic             out_valid,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] re_q [DEPTH];
  logic [WIDTH-1:0] re_d [DEPTH];
  logic [WIDTH-1:0] im_q [DEPTH];
  logic [WIDTH-1:0] im_d [DEPTH];
  logic [CW-1:0]    fill_q, fill_d;

  logic [LW-1:0]    len_eff;
  logic [AW-1:0]    tap;

  // Clamp requested length into 1..DEPTH
  always_comb begin
    len_eff = len;
    if (len == '0) begin
      len_eff = LW'(1);
    end else if (32'(len) > DEPTH) begin
      len_eff = LW'(DEPTH);
    end
    tap = AW'(len_eff - LW'(1));
  end

  // Next-state: flush beats shift, otherwise hold
  always_comb begin
    valid_d = valid_q;
    fill_d  = fill_q;
    for (int k = 0; k < int'(DEPTH); k++) begin
      re_d[k] = re_q[k];
      im_d[k] = im_q[k];
    end
    if (clr) begin
      valid_d = '0;
      fill_d  = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        re_d[k] = '0;
        im_d[k] = '0;
      end
    end else if (en) begin
      valid_d = {valid_q[DEPTH-2:0], in_valid};
      re_d[0] = in_r;
      im_d[0] = in_i;
      for (int k = 1; k < int'(DEPTH); k++) begin
        re_d[k] = re_q[k-1];
        im_d[k] = im_q[k-1];
      end
      if (32'(fill_q) < DEPTH) begin
        fill_d = fill_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      fill_q  <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      fill_q  <= fill_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        re_q[k] <= re_d[k];
        im_q[k] <= im_d[k];
      end
    end
  end

  // Tap and fill flag follow len immediately, from stored state only
  always_comb begin
    out_r     = re_q[tap];
    out_i     = im_q[tap];
    out_valid = valid_q[tap];
    full      = (32'(fill_q) >= 32'(len_eff));
  end

endmodule
